uart_tx_sched: RTL

Transmit-side scheduler for the UART IP core. It drains bytes from the TX `fifo_buf` instance one at a time and hands each byte to the UART transmitter serializer with a start/done handshake. It gates transfers on a software enable and the synchronized CTS flow-control input. A transmitter that never finishes is caught by a timeout watchdog, and the block keeps a count of bytes sent.

---
 rtl/uart_tx_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops bytes from the TX FIFO and hands each one to the
// serializer with a start/done handshake. It is gated by enable/CTS and guarded by a watchdog.
module uart_tx_sched #(
   parameter int W       = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cts_n,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [W-1:0]     fifo_r_data,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic             tx_start,
   output logic [W-1:0]     tx_data,
   output logic             active,
   output logic             tx_err,
   output logic [CNT_W-1:0] byte_count,
   input  logic             clr_count
);

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_LATCH = 2'd2,
      S_WAIT  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             ctsMeta_q, ctsSync_q;
   logic             txStart_q, txStart_d;
   logic [W-1:0]     txData_q, txData_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             txErr_q, txErr_d;
   logic             active_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ctsOk;
   logic             go;

   // The synchronizer resets to "not clear to send", so no fetch can happen until CTS is seen low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctsMeta_q <= 1'b1;
         ctsSync_q <= 1'b1;
      end else begin
         ctsMeta_q <= cts_n;
         ctsSync_q <= ctsMeta_q;
      end
   end

   assign ctsOk = ~ctsSync_q;
   assign go    = enable & ctsOk & ~fifo_empty & ~tx_busy;

   always_comb begin
      state_d   = state_q;
      txStart_d = 1'b0;
      txData_d  = txData_q;
      wd_d      = wd_q;
      txErr_d   = 1'b0;
      count_d   = count_q;
      case (state_q)
         S_IDLE: begin
            if (go) state_d = S_READ;
         end
         S_READ: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            txData_d  = fifo_r_data;
            txStart_d = 1'b1;
            wd_d      = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            // A done coinciding with the start pulse belongs to no byte of ours.
            if (tx_done && !txStart_q) begin
               if (count_q != '1) count_d = count_q + CNT_W'(1);
               state_d = go ? S_READ : S_IDLE;
            end else if (wd_q == WD_LAST) begin
               txErr_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clr_count) count_d = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         txStart_q <= 1'b0;
         txData_q  <= '0;
         wd_q      <= '0;
         txErr_q   <= 1'b0;
         active_q  <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         txStart_q <= txStart_d;
         txData_q  <= txData_d;
         wd_q      <= wd_d;
         txErr_q   <= txErr_d;
         active_q  <= (state_d != S_IDLE);
         count_q   <= count_d;
      end
   end

   assign fifo_rd_en = (state_q == S_READ);
   assign tx_start   = txStart_q;
   assign tx_data    = txData_q;
   assign active     = active_q;
   assign tx_err     = txErr_q;
   assign byte_count = count_q;

endmodule
